// File: rtl/dm_access_ctrl.sv
// Data-memory access sequencer for the MEM stage: drives a req/ack memory port,
// stalls the front of the pipeline until completion and flags bus timeouts.
module dm_access_ctrl #(
    parameter int          TIMEOUT  = 15,
    parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MEM_RD_EN,
    input  logic        MEM_WR_EN,
    input  logic [31:0] MEM_ADDR,
    input  logic [31:0] MEM_WDATA,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic [31:0] MEM_DM_Q,
    output logic        stall,
    output logic        bus_err,
    output logic [31:0] err_addr,
    input  logic        err_clr,
    output logic [1:0]  fsm_state
);

    // Handshake: dm_req rises on entry to WAIT and stays high, with dm_we/dm_addr/
    // dm_wdata frozen, until the single-cycle dm_ack or the timeout drops it.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] cnt;
    logic       access;
    logic       timeout_hit;

    assign access      = MEM_RD_EN | MEM_WR_EN;
    assign timeout_hit = (cnt == 8'(TIMEOUT - 1));
    assign stall       = (state == S_WAIT) || ((state == S_IDLE) && access);
    assign fsm_state   = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= 8'd0;
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_addr  <= 32'd0;
            dm_wdata <= 32'd0;
            MEM_DM_Q <= 32'd0;
            bus_err  <= 1'b0;
            err_addr <= 32'd0;
        end else begin
            if (err_clr) begin
                bus_err  <= 1'b0;
                err_addr <= 32'd0;
            end
            case (state)
                S_IDLE: begin
                    if (access) begin
                        dm_addr  <= MEM_ADDR;
                        dm_wdata <= MEM_WDATA;
                        dm_we    <= MEM_WR_EN;
                        dm_req   <= 1'b1;
                        cnt      <= 8'd0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (dm_ack) begin
                        dm_req <= 1'b0;
                        if (!dm_we) MEM_DM_Q <= dm_rdata;
                        state <= S_DONE;
                    end else if (timeout_hit) begin
                        dm_req <= 1'b0;
                        if (!dm_we) MEM_DM_Q <= ERR_DATA;
                        // Keep the first error, but a fresh one overrides a same-cycle clear.
                        if (!bus_err || err_clr) begin
                            bus_err  <= 1'b1;
                            err_addr <= dm_addr;
                        end
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl: driver tasks push expected completions,
// a negedge monitor pops and compares them on every DONE cycle.
module tb_dm_access_ctrl;

    localparam int          TIMEOUT  = 15;
    localparam logic [31:0] ERR_DATA = 32'h0000_0000;
    localparam int          W        = 146;

    logic        clk;
    logic        rst_n;
    logic        MEM_RD_EN, MEM_WR_EN;
    logic [31:0] MEM_ADDR, MEM_WDATA;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic [31:0] MEM_DM_Q;
    logic        stall, bus_err;
    logic [31:0] err_addr;
    logic        err_clr;
    logic [1:0]  fsm_state;

    int n_total  = 0;
    int n_passed = 0;
    int req_pulses = 0;

    // {q[145:114], err[113], eaddr[112:81], stalls[80:73], we[72], addr[71:40], wdata[39:8], reqc[7:0]}
    logic [W-1:0] exp_q[$];

    dm_access_ctrl #(.TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
        .clk(clk), .rst_n(rst_n),
        .MEM_RD_EN(MEM_RD_EN), .MEM_WR_EN(MEM_WR_EN),
        .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .MEM_DM_Q(MEM_DM_Q), .stall(stall),
        .bus_err(bus_err), .err_addr(err_addr), .err_clr(err_clr),
        .fsm_state(fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: act=running req=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_passed++;
        else $display("FAIL %s: act=%h exp=%h", name, act, exp);
    endtask

    // driver: one MEM-stage access, ack in WAIT cycle ack_at (0 = never)
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int ack_at,
                          input logic [31:0] rdata, input logic [31:0] exp_q_val,
                          input logic exp_err, input logic [31:0] exp_eaddr);
        int reqc;
        int cyc;
        reqc = (ack_at > 0 && ack_at <= TIMEOUT) ? ack_at : TIMEOUT;
        exp_q.push_back({exp_q_val, exp_err, exp_eaddr, 8'(reqc + 1), wr, addr, wdata, 8'(reqc)});
        MEM_RD_EN = rd; MEM_WR_EN = wr; MEM_ADDR = addr; MEM_WDATA = wdata;
        @(posedge clk); #1;
        cyc = 1;
        while (fsm_state != 2'd2 && cyc <= 40) begin
            if (cyc == ack_at) begin dm_ack = 1'b1; dm_rdata = rdata; end
            @(posedge clk); #1;
            dm_ack = 1'b0;
            cyc++;
        end
        chk("done_reached", {31'd0, fsm_state == 2'd2}, 32'd1);
        @(posedge clk); #1;
        MEM_RD_EN = 1'b0; MEM_WR_EN = 1'b0;
        chk("idle_after_done", {30'd0, fsm_state}, 32'd0);
    endtask

    // scoreboard monitor
    initial begin
        int          stalls, reqc;
        logic        unstable, prev_req;
        logic        c_we;
        logic [31:0] c_addr, c_wdata;
        logic [W-1:0] e;
        stalls = 0; reqc = 0; unstable = 0; prev_req = 0;
        c_we = 0; c_addr = 0; c_wdata = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalls = 0; reqc = 0; unstable = 0; prev_req = 0;
            end else begin
                if (dm_req && !prev_req) req_pulses++;
                prev_req = dm_req;
                if (stall) stalls++;
                if (dm_req) begin
                    if (reqc == 0) begin
                        c_we = dm_we; c_addr = dm_addr; c_wdata = dm_wdata;
                    end else if (c_we !== dm_we || c_addr !== dm_addr || c_wdata !== dm_wdata) begin
                        unstable = 1'b1;
                    end
                    reqc++;
                end
                if (fsm_state == 2'd2) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("mem_dm_q", MEM_DM_Q, e[145:114]);
                        chk("bus_err", {31'd0, bus_err}, {31'd0, e[113]});
                        chk("err_addr", err_addr, e[112:81]);
                        chk("stall_cycles", 32'(stalls), {24'd0, e[80:73]});
                        chk("dm_we", {31'd0, c_we}, {31'd0, e[72]});
                        chk("dm_addr", c_addr, e[71:40]);
                        chk("dm_wdata", c_wdata, e[39:8]);
                        chk("req_cycles", 32'(reqc), {24'd0, e[7:0]});
                        chk("req_stable", {31'd0, unstable}, 32'd0);
                        chk("stall_in_done", {31'd0, stall}, 32'd0);
                    end
                    stalls = 0; reqc = 0; unstable = 0;
                end
            end
        end
    end

    // stimulus
    initial begin
        rst_n = 1'b0; MEM_RD_EN = 0; MEM_WR_EN = 0; MEM_ADDR = 0; MEM_WDATA = 0;
        dm_ack = 0; dm_rdata = 0; err_clr = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dm_req", {31'd0, dm_req}, 32'd0);
        chk("rst_dm_we", {31'd0, dm_we}, 32'd0);
        chk("rst_dm_addr", dm_addr, 32'd0);
        chk("rst_dm_wdata", dm_wdata, 32'd0);
        chk("rst_mem_dm_q", MEM_DM_Q, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        chk("rst_err_addr", err_addr, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_state", {30'd0, fsm_state}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        access(1, 0, 32'h0000_0100, 32'h0, 1, 32'hCAFE_0001, 32'hCAFE_0001, 0, 32'h0);
        access(0, 1, 32'h0000_0040, 32'h1234_5678, 3, 32'hFFFF_FFFF, 32'hCAFE_0001, 0, 32'h0);
        access(1, 0, 32'h0000_0200, 32'h0, 1, 32'h1111_1111, 32'h1111_1111, 0, 32'h0);
        access(1, 0, 32'h0000_0204, 32'h0, 1, 32'h2222_2222, 32'h2222_2222, 0, 32'h0);
        access(1, 0, 32'h0000_0208, 32'h0, 1, 32'h3333_3333, 32'h3333_3333, 0, 32'h0);
        access(1, 0, 32'h0000_0BAD, 32'h0, 0, 32'h0, ERR_DATA, 1, 32'h0000_0BAD);
        access(1, 0, 32'h0000_0C00, 32'h0, 0, 32'h0, ERR_DATA, 1, 32'h0000_0BAD);

        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("clr_bus_err", {31'd0, bus_err}, 32'd0);
        chk("clr_err_addr", err_addr, 32'd0);

        access(1, 1, 32'h0000_0300, 32'hAAAA_5555, TIMEOUT, 32'h7777_7777, ERR_DATA, 0, 32'h0);

        err_clr = 1'b1;
        access(1, 0, 32'h0000_0D00, 32'h0, 0, 32'h0, ERR_DATA, 1, 32'h0000_0D00);
        err_clr = 1'b0;
        chk("clr_after_set_bus_err", {31'd0, bus_err}, 32'd0);

        // reset in the middle of a WAIT
        MEM_RD_EN = 1'b1; MEM_ADDR = 32'h0000_0500;
        @(posedge clk); #1;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0; MEM_RD_EN = 1'b0;
        #1;
        chk("midrst_dm_req", {31'd0, dm_req}, 32'd0);
        chk("midrst_dm_addr", dm_addr, 32'd0);
        chk("midrst_state", {30'd0, fsm_state}, 32'd0);
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        dm_ack = 1'b1; dm_rdata = 32'h0BAD_BAD0;
        @(posedge clk); #1;
        dm_ack = 1'b0;
        chk("stray_ack_state", {30'd0, fsm_state}, 32'd0);
        chk("stray_ack_req", {31'd0, dm_req}, 32'd0);
        chk("stray_ack_q", MEM_DM_Q, 32'd0);

        access(1, 0, 32'h0000_0400, 32'h0, 2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("req_pulses", 32'(req_pulses), 32'd11);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
- Sequences every data-memory access issued by the MEM stage of the 32-bit pipeline against a variable-latency data memory with a req/ack handshake.
- Holds the IF..MEM pipeline registers via a stall output until the access completes.
- Presents the captured read word to the MEM_WB register on the single cycle in which the pipeline advances.
- Enforces a bus timeout and reports a sticky error with the faulting address.

Parameters:
TIMEOUT, 15, maximum WAIT cycles without dm_ack before the access is aborted (1..255)
ERR_DATA, 32'h0000_0000, read word returned on a timed-out load

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
MEM_RD_EN  in  1  MEM-stage instruction is a load
MEM_WR_EN  in  1  MEM-stage instruction is a store
MEM_ADDR  in  32  MEM-stage effective address (ALU result)
MEM_WDATA  in  32  MEM-stage store data
dm_req  out  1  memory request, registered
dm_we  out  1  1 = write, 0 = read, registered
dm_addr  out  32  latched address, registered
dm_wdata  out  32  latched store data, registered
dm_ack  in  1  memory completion, single-cycle pulse
dm_rdata  in  32  read data, valid when dm_ack=1
MEM_DM_Q  out  32  captured read word, feeds MEM_WB
stall  out  1  freeze PC and IF_ID/ID_EX/EX_MEM, combinational
bus_err  out  1  sticky timeout flag
err_addr  out  32  address of first timed-out access
err_clr  in  1  clears bus_err and err_addr

Behaviour:
- Reset (async, rst_n=0): state IDLE, dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0, MEM_DM_Q=0, bus_err=0, err_addr=0, timeout counter=0.
- Reset mid-access drops dm_req immediately. A dm_ack arriving afterwards is ignored.
- States: IDLE, WAIT, DONE.
- IDLE:
  - If MEM_RD_EN|MEM_WR_EN, then stall=1 in that same cycle.
  - Next edge: latch MEM_ADDR/MEM_WDATA into dm_addr/dm_wdata, set dm_we=MEM_WR_EN, dm_req=1, counter=0, go to WAIT.
  - Both enables high is treated as a store (dm_we=1).
  - With no enable high, stall=0 and the state stays IDLE.
- WAIT:
  - stall=1. dm_req, dm_we, dm_addr and dm_wdata are held stable.
  - On dm_ack=1: dm_req<=0. If dm_we=0, MEM_DM_Q<=dm_rdata. Go to DONE.
  - Without ack, counter increments. When counter==TIMEOUT-1 and no ack:
    - dm_req<=0.
    - For a load, MEM_DM_Q<=ERR_DATA.
    - If bus_err==0, set bus_err<=1 and err_addr<=dm_addr. The first error is preserved.
    - Go to DONE.
  - An ack in the same cycle as the timeout wins: normal completion, no error.
- DONE:
  - stall=0 for exactly one cycle, so the pipeline advances and MEM_WB captures MEM_DM_Q.
  - Enables seen in DONE belong to the departing instruction and are ignored.
  - Next edge: go to IDLE.
- MEM_DM_Q holds its value outside completion and is unchanged by stores.
- Latency: zero-wait memory (ack on first WAIT cycle) gives 2 stall cycles per access. N-cycle ack gives N+1 stall cycles.
- Back-to-back accesses: IDLE, WAIT, DONE, IDLE, WAIT, and so on. No access is ever issued from DONE.
- dm_ack while IDLE or DONE: ignored, no state change.
- err_clr: clears bus_err/err_addr on the next edge. If err_clr coincides with a timeout, the new error wins (set dominates clear).
- Counter width: 8 bits. No wrap is possible because it is reset on entry to WAIT.

Test Plan:
- Load, memory acks on first WAIT cycle with dm_rdata=32'hCAFE_0001 -> stall high for 2 cycles, dm_req high 1 cycle with dm_we=0 and dm_addr=MEM_ADDR; in DONE, MEM_DM_Q=32'hCAFE_0001 and stall=0.
- Store to 32'h0000_0040 with data 32'h1234_5678, ack after 3 WAIT cycles -> dm_we=1, dm_wdata stable for 3 cycles, 4 stall cycles, MEM_DM_Q unchanged.
- Load to 32'h0000_0BAD, no ack, TIMEOUT=15 -> dm_req drops after 15 WAIT cycles, MEM_DM_Q=ERR_DATA, bus_err=1, err_addr=32'h0000_0BAD; a second timeout to 32'h0000_0C00 leaves err_addr=32'h0000_0BAD; err_clr -> both cleared.
- Three consecutive loads, each acked immediately -> IDLE/WAIT/DONE pattern repeats, exactly 3 dm_req pulses, no request issued from DONE, each MEM_DM_Q matches its dm_rdata.
- rst_n low during WAIT, then a stray ack after reset release -> dm_req=0 asynchronously, all outputs at reset values, state IDLE, stray ack ignored.
- MEM_RD_EN=MEM_WR_EN=1 -> dm_we=1; ack on the exact timeout cycle -> normal completion with bus_err=0.
